capture_ctrl: RTL
=================

Name: capture_ctrl

Overview:
Capture sequencer for the 5-channel logic-analyzer sample RAMs. It gates decimated sample writes into the shared circular RAM address space and arms once enough pre-trigger samples are stored. It then counts post-trigger samples up to trig_pos and signals completion to the command/config block. The completion signal sets the capture-done bit in TrigCfg. Its ram_addr output tells the dump path where the oldest sample begins (ram_addr+1, wrapping at ENTRIES).

Parameters:
ENTRIES, 384, depth of each channel RAM in samples
LOG2, 9, address width; ENTRIES <= 2**LOG2

Ports:
clk  in  1  system clock
rst_n  in  1  async active-low reset
run  in  1  capture enable (TrigCfg run bit); level
capture_done  in  1  TrigCfg capture-done bit, fed back from config block
wrt_smpl  in  1  one-cycle strobe from decimator: a new sample is valid this cycle
triggered  in  1  trigger event from trigger logic; sampled each cycle
trig_pos  in  LOG2  number of post-trigger samples to store
we  out  1  RAM write enable, common to all 5 channels
waddr  out  LOG2  RAM write address, valid when we=1
ram_addr  out  LOG2  address of last sample written
armed  out  1  enough pre-trigger samples stored; trigger accepted
set_capture_done  out  1  one-cycle pulse at end of capture

Behaviour:
- Reset:
  - State IDLE; waddr=0, ram_addr=0, armed=0, we=0, set_capture_done=0.
  - Internal smpl_cnt=0, trig_cnt=0.
- Effective trig_pos: tp = (trig_pos >= ENTRIES) ? ENTRIES-1 : trig_pos.
- States: IDLE, RUN, TRIG, DONE, WAIT (registered state, combinational next-state).
- we = wrt_smpl && (state==RUN || state==TRIG). This is combinational, same cycle as wrt_smpl. waddr is the registered write pointer.
- On each write:
  - waddr <= (waddr==ENTRIES-1) ? 0 : waddr+1.
  - ram_addr <= waddr.
  - smpl_cnt <= smpl_cnt+1, saturating at ENTRIES.
- IDLE:
  - If run && !capture_done: go to RUN; clear waddr, smpl_cnt, trig_cnt and armed.
  - Otherwise stay. ram_addr holds, so a dump after capture reads the correct window.
- RUN:
  - armed is registered: armed <= (smpl_cnt_next >= ENTRIES - tp). It rises the cycle after the qualifying write.
  - If triggered && armed: go to TRIG with trig_cnt=0. If tp==0, go directly to DONE instead.
  - If triggered && !armed: ignore the trigger and stay in RUN.
- TRIG:
  - On each write, trig_cnt <= trig_cnt+1.
  - If trig_cnt+1 == tp on a write cycle, go to DONE; that write still occurs.
  - triggered is ignored in TRIG.
- DONE:
  - set_capture_done=1 for exactly one cycle; we forced 0.
  - Go to WAIT.
- WAIT:
  - we=0; stay while capture_done==1.
  - Go to IDLE when capture_done==0 (host cleared it through a TrigCfg write).
- run deasserted in RUN or TRIG: abort to IDLE next cycle. No set_capture_done; armed cleared; ram_addr holds the last written address.
- wrt_smpl and a state exit in the same cycle: the write is qualified by the current state only.
- Wrap-around: waddr wraps ENTRIES-1 -> 0, and is never equal to or greater than ENTRIES. ENTRIES need not be a power of two.
- Reset mid-capture: all outputs return to reset values asynchronously; no pulse is emitted.

Test Plan:
1. Reset, no run: pulse wrt_smpl 10 times -> we never asserts; waddr=0, ram_addr=0, set_capture_done=0.
2. Normal capture (ENTRIES=384, trig_pos=100):
   - run=1 with continuous wrt_smpl -> armed rises the cycle after the 284th write.
   - Trigger there -> exactly 100 further writes.
   - One set_capture_done pulse; we=0 afterwards.
   - ram_addr = (284+100-1) mod 384 = 383.
3. Early trigger: triggered pulsed after 50 writes (trig_pos=100) -> ignored, stays RUN. Re-trigger after armed -> completes as in scenario 2.
4. Wrap: trig_pos=10, trigger after 500 writes -> waddr wraps 383 -> 0. ram_addr = (510-1) mod 384 = 125; no address >= 384 ever appears.
5. Edge values:
   - trig_pos=0: trigger once armed -> DONE on the next cycle with no post-trigger writes.
   - trig_pos=511: treated as 383 -> armed after 1 write; done after 383 post-trigger writes.
6. Abort and handshake:
   - run dropped in TRIG -> IDLE, no set_capture_done.
   - In WAIT with capture_done=1 and run=1 -> no restart. Clearing capture_done -> IDLE, then RUN the following cycle.

Source files
------------

// File: rtl/capture_ctrl_if.sv
// Capture-controller signal bundle between the TrigCfg/decimator side and the
// capture sequencer. master drives the controls, slave is the sequencer.
interface capture_ctrl_if #(
  parameter int LOG2 = 9
);
  logic            run;
  logic            capture_done;
  logic            wrt_smpl;
  logic            triggered;
  logic [LOG2-1:0] trig_pos;
  logic            we;
  logic [LOG2-1:0] waddr;
  logic [LOG2-1:0] ram_addr;
  logic            armed;
  logic            set_capture_done;

  modport master (
    output run, capture_done, wrt_smpl, triggered, trig_pos,
    input  we, waddr, ram_addr, armed, set_capture_done
  );

  modport slave (
    input  run, capture_done, wrt_smpl, triggered, trig_pos,
    output we, waddr, ram_addr, armed, set_capture_done
  );
endinterface

// File: rtl/capture_ctrl.sv
// Capture sequencer for the logic-analyzer sample RAMs: circular write
// pointer, pre-trigger arming, post-trigger count and done handshake.
//
// state  | meaning
// IDLE   | not capturing; ram_addr frozen for dump
// RUN    | filling pre-trigger history, waiting for an accepted trigger
// TRIG   | storing post-trigger samples until tp are written
// DONE   | one-cycle set_capture_done pulse
// WAIT   | hold until host clears capture_done
module capture_ctrl #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic           clk,
  input  logic           rst_n,
  capture_ctrl_if.slave  cap
);
  localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);
  localparam logic [LOG2:0]   ENT  = (LOG2 + 1)'(ENTRIES);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_TRIG, S_DONE, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic [LOG2-1:0] waddr_q, waddr_d;
  logic [LOG2-1:0] ram_addr_q, ram_addr_d;
  logic [LOG2-1:0] trig_cnt_q, trig_cnt_d, trig_cnt_inc;
  logic [LOG2:0]   smpl_cnt_q, smpl_cnt_d, smpl_cnt_nxt;
  logic            armed_q, armed_d;
  logic [LOG2-1:0] tp;
  logic [LOG2:0]   arm_thr;
  logic            we;

  // Post-trigger count can never exceed one RAM's worth minus the trigger slot.
  assign tp           = ({1'b0, cap.trig_pos} >= ENT) ? LAST : cap.trig_pos;
  assign arm_thr      = ENT - {1'b0, tp};
  assign we           = cap.wrt_smpl && (state_q == S_RUN || state_q == S_TRIG);
  assign trig_cnt_inc = trig_cnt_q + 1'b1;

  always_comb begin
    smpl_cnt_nxt = smpl_cnt_q;
    if (we && smpl_cnt_q != ENT) smpl_cnt_nxt = smpl_cnt_q + 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    waddr_d    = waddr_q;
    ram_addr_d = ram_addr_q;
    smpl_cnt_d = smpl_cnt_nxt;
    trig_cnt_d = trig_cnt_q;
    armed_d    = armed_q;

    if (we) begin
      waddr_d    = (waddr_q == LAST) ? '0 : waddr_q + 1'b1;
      ram_addr_d = waddr_q;
    end

    case (state_q)
      S_IDLE: begin
        if (cap.run && !cap.capture_done) begin
          state_d    = S_RUN;
          waddr_d    = '0;
          smpl_cnt_d = '0;
          trig_cnt_d = '0;
          armed_d    = 1'b0;
        end
      end
      S_RUN: begin
        if (!cap.run) begin
          state_d = S_IDLE;
          armed_d = 1'b0;
        end else begin
          armed_d = (smpl_cnt_nxt >= arm_thr);
          if (cap.triggered && armed_q) begin
            trig_cnt_d = '0;
            state_d    = (tp == '0) ? S_DONE : S_TRIG;
          end
        end
      end
      S_TRIG: begin
        if (!cap.run) begin
          state_d = S_IDLE;
          armed_d = 1'b0;
        end else if (we) begin
          trig_cnt_d = trig_cnt_inc;
          if (trig_cnt_inc == tp) state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_WAIT;
      S_WAIT: begin
        if (!cap.capture_done) begin
          state_d = S_IDLE;
          armed_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      waddr_q    <= '0;
      ram_addr_q <= '0;
      smpl_cnt_q <= '0;
      trig_cnt_q <= '0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      waddr_q    <= waddr_d;
      ram_addr_q <= ram_addr_d;
      smpl_cnt_q <= smpl_cnt_d;
      trig_cnt_q <= trig_cnt_d;
      armed_q    <= armed_d;
    end
  end

  assign cap.we               = we;
  assign cap.waddr            = waddr_q;
  assign cap.ram_addr         = ram_addr_q;
  assign cap.armed            = armed_q;
  assign cap.set_capture_done = (state_q == S_DONE);
endmodule
